sd_drive_arbiter: RTL

//  Shares the single host SD block interface (hps_io sd_lba/rd/wr/ack/buff) among NDR drive

---
 rtl/sd_arb_pkg.sv | 24 ++
 rtl/rr_pick.sv | 35 +++
 rtl/sd_drive_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD drive arbiter.
// Host field widths, arbiter FSM states and the round-robin index step.
package sd_arb_pkg;

  localparam int unsigned SD_LBA_W = 32;
  localparam int unsigned SD_BLK_W = 6;
  localparam int unsigned MAX_NDR  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StXfer,
    StGap
  } arb_state_e;

  // Step a drive index by one, wrapping at the real drive count rather than MAX_NDR.
  function automatic logic [1:0] next_idx(logic [1:0] idx, int unsigned n);
    if (32'(idx) + 32'd1 >= n) begin
      return 2'd0;
    end
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Returns the first set request at or after ptr, searching upward and wrapping at N.
module rr_pick
  import sd_arb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   ptr,
  output logic         valid,
  output logic [1:0]   idx
);

  logic [MAX_NDR-1:0] req_ext;
  logic [2:0]         cand;

  assign req_ext = MAX_NDR'(req);

  always_comb begin
    valid = 1'b0;
    idx   = 2'd0;
    cand  = 3'd0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + 3'(k);
      if (32'(cand) >= N) begin
        cand = cand - 3'(N);
      end
      if (!valid && req_ext[cand[1:0]]) begin
        valid = 1'b1;
        idx   = cand[1:0];
      end
    end
  end

endmodule

// File: rtl/sd_drive_arbiter.sv
// Shares one host SD block port among NDR drives: round-robin grant, one transfer in flight,
// request fields latched at grant and ack routed back to the granted drive only.
module sd_drive_arbiter
  import sd_arb_pkg::*;
#(
  parameter int unsigned NDR     = 2,
  parameter int unsigned TIMEOUT = 2**22
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic [NDR*SD_LBA_W-1:0] drv_lba,
  input  logic [NDR*SD_BLK_W-1:0] drv_blk_cnt,
  input  logic [NDR-1:0]          drv_rd,
  input  logic [NDR-1:0]          drv_wr,
  input  logic [NDR*8-1:0]        drv_buff_din,
  output logic [NDR-1:0]          drv_ack,
  output logic [SD_LBA_W-1:0]     sd_lba,
  output logic [SD_BLK_W-1:0]     sd_blk_cnt,
  output logic                    sd_rd,
  output logic                    sd_wr,
  input  logic                    sd_ack,
  output logic [7:0]              sd_buff_din,
  output logic                    busy,
  output logic [1:0]              grant,
  output logic                    timeout_err
);

  localparam int unsigned   TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  // Per-drive views padded to MAX_NDR so a 2-bit index never leaves the array.
  logic [SD_LBA_W-1:0] lba_arr [MAX_NDR];
  logic [SD_BLK_W-1:0] cnt_arr [MAX_NDR];
  logic [7:0]          din_arr [MAX_NDR];
  logic [MAX_NDR-1:0]  rd_ext;
  logic [MAX_NDR-1:0]  req_ext;

  for (genvar i = 0; i < MAX_NDR; i++) begin : g_unpack
    if (i < NDR) begin : g_drv
      assign lba_arr[i] = drv_lba[i*SD_LBA_W +: SD_LBA_W];
      assign cnt_arr[i] = drv_blk_cnt[i*SD_BLK_W +: SD_BLK_W];
      assign din_arr[i] = drv_buff_din[i*8 +: 8];
      assign rd_ext[i]  = drv_rd[i];
      assign req_ext[i] = drv_rd[i] | drv_wr[i];
    end else begin : g_pad
      assign lba_arr[i] = '0;
      assign cnt_arr[i] = '0;
      assign din_arr[i] = '0;
      assign rd_ext[i]  = 1'b0;
      assign req_ext[i] = 1'b0;
    end
  end

  arb_state_e          state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [SD_LBA_W-1:0] lba_q, lba_d;
  logic [SD_BLK_W-1:0] cnt_q, cnt_d;
  logic                dir_wr_q, dir_wr_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                err_q, err_d;

  logic                pick_valid;
  logic [1:0]          pick_idx;

  rr_pick #(
    .N(NDR)
  ) u_rr_pick (
    .req  (drv_rd | drv_wr),
    .ptr  (ptr_q),
    .valid(pick_valid),
    .idx  (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    lba_d    = lba_q;
    cnt_d    = cnt_q;
    dir_wr_d = dir_wr_q;
    timer_d  = timer_q;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d  = pick_idx;
          lba_d    = lba_arr[pick_idx];
          cnt_d    = cnt_arr[pick_idx];
          dir_wr_d = ~rd_ext[pick_idx];
          timer_d  = '0;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        // Ack beats a same-cycle withdrawal; the host has already committed.
        if (sd_ack) begin
          state_d = StXfer;
        end else if (!req_ext[grant_q]) begin
          state_d = StIdle;
        end else if (timer_q == TMAX) begin
          err_d   = 1'b1;
          ptr_d   = next_idx(grant_q, NDR);
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StXfer: begin
        if (!sd_ack) begin
          state_d = StGap;
        end
      end
      StGap: begin
        ptr_d   = next_idx(grant_q, NDR);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      grant_q  <= 2'd0;
      ptr_q    <= 2'd0;
      lba_q    <= '0;
      cnt_q    <= '0;
      dir_wr_q <= 1'b0;
      timer_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      lba_q    <= lba_d;
      cnt_q    <= cnt_d;
      dir_wr_q <= dir_wr_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    drv_ack = '0;
    for (int unsigned i = 0; i < NDR; i++) begin
      drv_ack[i] = (state_q == StXfer) && sd_ack && (grant_q == 2'(i));
    end
  end

  assign sd_rd       = (state_q == StIssue) && !dir_wr_q;
  assign sd_wr       = (state_q == StIssue) && dir_wr_q;
  assign busy        = (state_q != StIdle);
  assign grant       = grant_q;
  assign sd_lba      = lba_q;
  assign sd_blk_cnt  = cnt_q;
  assign timeout_err = err_q;
  assign sd_buff_din = din_arr[grant_q];

endmodule
